// File: rtl/qa_drv_hc_write_arb_pkg.sv
// Shared host-channel types: CCI write header, arbiter request bundle and
// the fixed requester index map used by the write arbiter.
package qa_drv_hc_types;

  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int N_WRITE_REQ      = 3;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_cci_c1_req;

  typedef struct packed {
    t_cci_c1_req req_type;
    logic [1:0]  cl_len;
    logic [15:0] mdata;
    logic [41:0] addr;
  } t_cci_mpf_ReqMemHdr;

  typedef struct packed {
    logic                        valid;
    t_cci_mpf_ReqMemHdr          hdr;
    logic [CCI_CLDATA_WIDTH-1:0] data;
  } t_write_arb_req;

  typedef enum logic [1:0] {
    WR_FIFO_TO_HOST,
    WR_STATUS,
    WR_DEBUG
  } t_write_req_idx;

endpackage

// File: rtl/qa_drv_hc_write_arb_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr (modulo N_REQ),
// one-hot result, all-zero when disabled. Shared with the read arbiter.
module qa_drv_hc_rr_pick #(
  parameter  int N_REQ = 3,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qa_drv_hc_write_arb.sv
// CCI TX1 write arbiter: round-robin grant among frame writers, registered
// TX1 issue, outstanding-write cap and a one-cycle bubble after each fence.
module qa_drv_hc_write_arb
  import qa_drv_hc_types::*;
#(
  parameter  int N_REQ           = N_WRITE_REQ,
  parameter  int MAX_OUTSTANDING = 64,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic               [N_REQ-1:0]          req_valid,
  input  t_cci_mpf_ReqMemHdr [N_REQ-1:0]          req_hdr,
  input  logic [N_REQ-1:0][CCI_CLDATA_WIDTH-1:0]  req_data,
  output logic               [N_REQ-1:0]          grant,
  output logic                                    can_issue,
  input  logic                                    tx1_almost_full,
  output logic                                    tx1_valid,
  output t_cci_mpf_ReqMemHdr                      tx1_hdr,
  output logic [CCI_CLDATA_WIDTH-1:0]             tx1_data,
  input  logic                                    rx_wr_ack,
  output logic [OUT_W-1:0]                        outstanding
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_idx;
  logic             fence_bubble;
  logic             any_grant;
  logic             win_fence;
  logic             inc;

  // Gated by reset_n so grant/can_issue read 0 during a reset cycle.
  assign can_issue = reset_n && !tx1_almost_full &&
                     (outstanding < OUT_W'(MAX_OUTSTANDING));

  qa_drv_hc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .enable (can_issue && !fence_bubble),
    .grant  (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  assign any_grant = |grant;
  assign win_fence = any_grant && (req_hdr[win_idx].req_type == eREQ_WRFENCE);
  assign inc       = any_grant && !win_fence;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx1_valid    <= 1'b0;
      tx1_hdr      <= '0;
      tx1_data     <= '0;
      outstanding  <= '0;
      rr_ptr       <= '0;
      fence_bubble <= 1'b0;
    end else begin
      tx1_valid    <= any_grant;
      fence_bubble <= win_fence;
      if (any_grant) begin
        tx1_hdr  <= req_hdr[win_idx];
        tx1_data <= req_data[win_idx];
        rr_ptr   <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      // Issue and ack together cancel; a stray ack at zero is dropped.
      if (inc && !rx_wr_ack)
        outstanding <= outstanding + 1'b1;
      else if (!inc && rx_wr_ack && (outstanding != '0))
        outstanding <= outstanding - 1'b1;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant));
  a_af_blocks_issue: assert property (@(posedge clk) disable iff (!reset_n)
    tx1_almost_full |=> !tx1_valid);
  c_ack_at_zero: cover property (@(posedge clk) disable iff (!reset_n)
    rx_wr_ack && (outstanding == '0));

endmodule

// File: tb/tb_qa_drv_hc_write_arb.sv
// Bench for qa_drv_hc_write_arb: two instances (cap 64 and cap 4) on shared
// stimulus, checked each cycle against a behavioural arbiter model.
module tb_qa_drv_hc_write_arb;
  import qa_drv_hc_types::*;

  localparam int N     = 3;
  localparam int MAX_A = 64;
  localparam int MAX_B = 4;
  localparam int OW_A  = $clog2(MAX_A + 1);
  localparam int OW_B  = $clog2(MAX_B + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  t_cci_mpf_ReqMemHdr [N-1:0] req_hdr = '0;
  logic [N-1:0][511:0] req_data = '0;
  logic tx1_almost_full = 1'b0;
  logic rx_wr_ack = 1'b0;

  logic [N-1:0] grant_a, grant_b;
  logic can_a, can_b, tv_a, tv_b;
  t_cci_mpf_ReqMemHdr th_a, th_b;
  logic [511:0] td_a, td_b;
  logic [OW_A-1:0] out_a;
  logic [OW_B-1:0] out_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qa_drv_hc_write_arb #(.N_REQ(N), .MAX_OUTSTANDING(MAX_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_hdr(req_hdr),
    .req_data(req_data), .grant(grant_a), .can_issue(can_a),
    .tx1_almost_full(tx1_almost_full), .tx1_valid(tv_a), .tx1_hdr(th_a),
    .tx1_data(td_a), .rx_wr_ack(rx_wr_ack), .outstanding(out_a));

  qa_drv_hc_write_arb #(.N_REQ(N), .MAX_OUTSTANDING(MAX_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_hdr(req_hdr),
    .req_data(req_data), .grant(grant_b), .can_issue(can_b),
    .tx1_almost_full(tx1_almost_full), .tx1_valid(tv_b), .tx1_hdr(th_b),
    .tx1_data(td_b), .rx_wr_ack(rx_wr_ack), .outstanding(out_b));

  // Model state per instance (0 = cap 64, 1 = cap 4).
  int                 m_rr[2];
  int                 m_out[2];
  bit                 m_bub[2];
  bit                 m_tv[2];
  t_cci_mpf_ReqMemHdr m_th[2];
  logic [511:0]       m_td[2];
  int                 last_p[2];

  function automatic int cap_of(int s);
    return (s == 0) ? MAX_A : MAX_B;
  endfunction

  function automatic bit m_can(int s);
    return reset_n && !tx1_almost_full && (m_out[s] < cap_of(s));
  endfunction

  // Index of the requester that must win this cycle, or -1.
  function automatic int m_pick(int s);
    if (!m_can(s) || m_bub[s]) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr[s] + k) % N]) return (m_rr[s] + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int p;
      int n;
      bit fence;
      if (!reset_n) begin
        m_rr[s] = 0; m_out[s] = 0; m_bub[s] = 0; m_tv[s] = 0;
        m_th[s] = '0; m_td[s] = '0; last_p[s] = -1;
      end else begin
        p = m_pick(s);
        last_p[s] = p;
        fence = (p >= 0) && (req_hdr[p].req_type == eREQ_WRFENCE);
        m_tv[s] = (p >= 0);
        if (p >= 0) begin
          m_th[s] = req_hdr[p];
          m_td[s] = req_data[p];
          m_rr[s] = (p + 1) % N;
        end
        m_bub[s] = fence;
        n = m_out[s] + ((p >= 0 && !fence) ? 1 : 0) - (rx_wr_ack ? 1 : 0);
        m_out[s] = (n < 0) ? 0 : n;
      end
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int p;
      logic [N-1:0] eg;
      string tag;
      tag = (s == 0) ? "A" : "B";
      p = m_pick(s);
      eg = '0;
      if (p >= 0) eg[p] = 1'b1;
      chk({tag, ".grant"}, (s == 0) ? grant_a : grant_b, eg);
      chk({tag, ".can_issue"}, (s == 0) ? can_a : can_b, m_can(s));
      chk({tag, ".tx1_valid"}, (s == 0) ? tv_a : tv_b, m_tv[s]);
      chk({tag, ".outstanding"}, (s == 0) ? 512'(out_a) : 512'(out_b), 512'(m_out[s]));
      if (m_tv[s]) begin
        chk({tag, ".tx1_hdr"}, (s == 0) ? th_a : th_b, m_th[s]);
        chk({tag, ".tx1_data"}, (s == 0) ? td_a : td_b, m_td[s]);
      end
    end
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int i, input bit fence);
    req_hdr[i].req_type = fence ? eREQ_WRFENCE :
                          (($urandom_range(0, 1) == 0) ? eREQ_WRLINE_I : eREQ_WRLINE_M);
    req_hdr[i].cl_len   = 2'b00;
    req_hdr[i].mdata    = 16'($urandom);
    req_hdr[i].addr     = 42'($urandom);
    req_data[i]         = rnd512();
  endtask

  // One cycle: drive just after the edge, return at the following negedge.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] f,
                     input logic af, input logic ack, input logic rst);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, f[i]);
    req_valid       = v;
    tx1_almost_full = af;
    rx_wr_ack       = ack;
    reset_n         = !rst;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [N-1:0] g;
    logic [N-1:0] pend;

    cyc(3'b000, 3'b000, 0, 0, 1);
    cyc(3'b111, 3'b000, 0, 0, 1);
    chk("rst_grant", grant_a, 3'b000);
    chk("rst_can_issue", can_a, 1'b0);
    chk("rst_tx1_valid", tv_a, 1'b0);
    chk("rst_outstanding", out_a, 0);
    chk("rst_tx1_data", td_a, 512'd0);

    // All three requesting: strict rotation 0,1,2,...
    for (int c = 0; c < 9; c++) begin
      cyc(3'b111, 3'b000, 0, 0, 0);
      g = 3'b001 << (c % 3);
      chk("rot_grant", grant_a, g);
    end
    cyc(3'b000, 3'b000, 0, 0, 0);
    chk("rot_outstanding", out_a, 9);
    chk("rot_last_tx1_valid", tv_a, 1'b1);
    cyc(3'b000, 3'b000, 0, 0, 0);
    chk("idle_tx1_valid", tv_a, 1'b0);

    // Drain with more acks than writes: count floors at zero.
    for (int c = 0; c < 12; c++) cyc(3'b000, 3'b000, 0, 1, 0);
    cyc(3'b000, 3'b000, 0, 0, 0);
    chk("drain_outstanding_a", out_a, 0);
    chk("drain_outstanding_b", out_b, 0);

    // Almost-full for cycles 3-5 stalls then resumes at the next index.
    for (int c = 0; c < 7; c++) begin
      cyc(3'b111, 3'b000, (c >= 3 && c <= 5), 0, 0);
      g = (c >= 3 && c <= 5) ? 3'b000 : (3'b001 << (c % 3));
      chk("af_grant", grant_a, g);
      if (c >= 3 && c <= 5) chk("af_can_issue", can_a, 1'b0);
      if (c == 4) chk("af_tx1_valid", tv_a, 1'b0);
    end

    // Cap of 4 on instance B: 4 grants, stall, one ack -> one more grant.
    cyc(3'b000, 3'b000, 0, 0, 1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(3'b111, 3'b000, 0, 0, 0);
      if (grant_b != 0) cnt++;
    end
    chk("cap_grants", cnt, 4);
    chk("cap_can_issue", can_b, 1'b0);
    chk("cap_outstanding", out_b, 4);
    cnt = 0;
    cyc(3'b111, 3'b000, 0, 1, 0);
    if (grant_b != 0) cnt++;
    for (int c = 0; c < 4; c++) begin
      cyc(3'b111, 3'b000, 0, 0, 0);
      if (grant_b != 0) cnt++;
    end
    chk("cap_after_ack_grants", cnt, 1);

    // Grant and ack in the same cycle keep the count.
    cyc(3'b000, 3'b000, 0, 0, 1);
    cyc(3'b001, 3'b000, 0, 0, 0);
    cyc(3'b001, 3'b000, 0, 0, 0);
    cyc(3'b001, 3'b000, 0, 1, 0);
    chk("same_cyc_before", out_a, 2);
    chk("same_cyc_grant", grant_a, 3'b001);
    cyc(3'b000, 3'b000, 0, 0, 0);
    chk("same_cyc_after", out_a, 2);

    // Fence from req0, write from req1.
    cyc(3'b000, 3'b000, 0, 0, 1);
    cyc(3'b011, 3'b001, 0, 0, 0);
    chk("fence_grant", grant_a, 3'b001);
    cyc(3'b010, 3'b000, 0, 0, 0);
    chk("fence_bubble", grant_a, 3'b000);
    cyc(3'b010, 3'b000, 0, 0, 0);
    chk("fence_then_write", grant_a, 3'b010);
    cyc(3'b000, 3'b000, 0, 0, 0);
    chk("fence_outstanding", out_a, 1);

    // Reset mid-operation.
    cyc(3'b000, 3'b000, 0, 0, 1);
    for (int c = 0; c < 5; c++) cyc(3'b001, 3'b000, 0, 0, 0);
    cyc(3'b111, 3'b000, 0, 0, 1);
    chk("pre_rst_outstanding", out_a, 5);
    chk("pre_rst_tx1_valid", tv_a, 1'b1);
    chk("in_rst_grant", grant_a, 3'b000);
    cyc(3'b111, 3'b000, 0, 1, 0);
    chk("post_rst_tx1_valid", tv_a, 1'b0);
    chk("post_rst_outstanding", out_a, 0);
    chk("post_rst_tx1_hdr", th_a, 64'd0);
    chk("post_rst_first_tie", grant_a, 3'b001);

    // Randomized traffic; requesters hold until instance A grants them.
    pend = '0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (last_p[0] >= 0) pend[last_p[0]] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, $urandom_range(0, 7) == 0);
        end
      end
      req_valid       = pend;
      tx1_almost_full = ($urandom_range(0, 4) == 0);
      rx_wr_ack       = ($urandom_range(0, 2) == 0);
      reset_n         = !($urandom_range(0, 299) == 0);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
